serial_adder: RTL

- Bit-serial adder for WIDTH-bit operands. Built around one 1-bit full-adder cell with a registered carry.
- Processes one bit per clock, LSB first. Result is presented as a parallel word with carry-out.
- Sits downstream of operand registers and upstream of result consumers.
- Trades latency for area against the ripple-carry adders in the lab set.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default operand width and FSM encoding.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder built from two half adders and an OR.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    logic w_p;
    logic w_g_ab;
    logic w_g_pc;

    assign w_p     = i_a ^ i_b;
    assign w_g_ab  = i_a & i_b;
    assign o_sum   = w_p ^ i_c;
    assign w_g_pc  = w_p & i_c;
    assign o_carry = w_g_ab | w_g_pc;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first,
// result presented as a parallel word plus carry-out after WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_res_next;

    fa_cell u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_c     (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    // The earliest result bit is only needed on the final edge, so it is never stored.
    assign w_res_next = {w_fa_sum, r_res_sh};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_carry  <= cin;
        end else if (r_state == ST_RUN) begin
            r_cnt    <= r_cnt + CW'(1);
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_next[WIDTH-1:1];
            r_carry  <= w_fa_carry;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
